// File: rtl/main_alu_checker.sv
// Response checker for main_alu: a reference model recomputes each issued
// operation, delays it LATENCY cycles and scores it against i_aluout.
module main_alu_checker #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [31:0]      i_op1,
  input  logic [31:0]      i_op2,
  input  logic [3:0]       i_opsel,
  input  logic [31:0]      i_aluout,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_checked,
  output logic [CNT_W-1:0] o_errors,
  output logic [CNT_W-1:0] o_skipped,
  output logic             o_fail,
  output logic [3:0]       o_first_opsel,
  output logic [31:0]      o_first_exp,
  output logic [31:0]      o_first_act,
  output logic [31:0]      o_signature
);

  typedef enum logic {RUN = 1'b0, FAILED = 1'b1} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [4:0]       shamt;
  logic [31:0]      ref_res;
  logic             ref_def;

  always_comb begin
    shamt   = i_op2[4:0];
    ref_res = '0;
    ref_def = 1'b1;
    case (i_opsel)
      4'b0000: ref_res = i_op1 + i_op2;
      4'b1000: ref_res = i_op1 - i_op2;
      4'b0001: ref_res = i_op1 << shamt;
      4'b0010: ref_res = {31'd0, $signed(i_op1) < $signed(i_op2)};
      4'b0011: ref_res = {31'd0, i_op1 < i_op2};
      4'b0100: ref_res = i_op1 ^ i_op2;
      4'b0101: ref_res = i_op1 >> shamt;
      4'b1101: ref_res = $unsigned($signed(i_op1) >>> shamt);
      4'b0110: ref_res = i_op1 | i_op2;
      4'b0111: ref_res = i_op1 & i_op2;
      default: ref_def = 1'b0;
    endcase
  end

  // Delay line: stage 0 is written at issue, stage LATENCY-1 is aligned with i_aluout.
  logic        pvld_q [LATENCY];
  logic        pvld_d [LATENCY];
  logic        pdef_q [LATENCY];
  logic        pdef_d [LATENCY];
  logic [3:0]  pop_q  [LATENCY];
  logic [3:0]  pop_d  [LATENCY];
  logic [31:0] pexp_q [LATENCY];
  logic [31:0] pexp_d [LATENCY];

  always_comb begin
    pvld_d[0] = i_valid;
    pdef_d[0] = ref_def;
    pop_d[0]  = i_opsel;
    pexp_d[0] = ref_res;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pvld_d[i] = pvld_q[i-1];
      pdef_d[i] = pdef_q[i-1];
      pop_d[i]  = pop_q[i-1];
      pexp_d[i] = pexp_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pvld_q[i] <= 1'b0;
        pdef_q[i] <= 1'b0;
        pop_q[i]  <= '0;
        pexp_q[i] <= '0;
      end
    end else begin
      pvld_q <= pvld_d;
      pdef_q <= pdef_d;
      pop_q  <= pop_d;
      pexp_q <= pexp_d;
    end
  end

  logic             al_vld, al_def, al_cmp, al_mis;
  logic [3:0]       al_op;
  logic [31:0]      al_exp;

  assign al_vld = pvld_q[LATENCY-1];
  assign al_def = pdef_q[LATENCY-1];
  assign al_op  = pop_q[LATENCY-1];
  assign al_exp = pexp_q[LATENCY-1];
  assign al_cmp = al_vld & al_def;
  assign al_mis = al_cmp & (al_exp != i_aluout);

  logic [CNT_W-1:0] checked_q, checked_d;
  logic [CNT_W-1:0] errors_q, errors_d;
  logic [CNT_W-1:0] skipped_q, skipped_d;
  logic             fail_q, fail_d;
  logic [3:0]       first_opsel_q, first_opsel_d;
  logic [31:0]      first_exp_q, first_exp_d;
  logic [31:0]      first_act_q, first_act_d;
  logic [31:0]      sig_q, sig_d;

  always_comb begin
    state_d       = state_q;
    checked_d     = checked_q;
    errors_d      = errors_q;
    skipped_d     = skipped_q;
    fail_d        = fail_q;
    first_opsel_d = first_opsel_q;
    first_exp_d   = first_exp_q;
    first_act_d   = first_act_q;
    sig_d         = sig_q;
    // Clear wins over any aligned result; the pipeline keeps running.
    if (i_clear) begin
      state_d       = RUN;
      checked_d     = '0;
      errors_d      = '0;
      skipped_d     = '0;
      fail_d        = 1'b0;
      first_opsel_d = '0;
      first_exp_d   = '0;
      first_act_d   = '0;
      sig_d         = '0;
    end else begin
      if (al_cmp) begin
        checked_d = (checked_q == '1) ? checked_q : checked_q + CNT_ONE;
        sig_d     = {sig_q[30:0], sig_q[31]} ^ i_aluout;
      end
      if (al_mis) begin
        errors_d = (errors_q == '1) ? errors_q : errors_q + CNT_ONE;
      end
      if (al_vld && !al_def) begin
        skipped_d = (skipped_q == '1) ? skipped_q : skipped_q + CNT_ONE;
      end
      if (al_mis && state_q == RUN) begin
        state_d       = FAILED;
        fail_d        = 1'b1;
        first_opsel_d = al_op;
        first_exp_d   = al_exp;
        first_act_d   = i_aluout;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= RUN;
      checked_q     <= '0;
      errors_q      <= '0;
      skipped_q     <= '0;
      fail_q        <= 1'b0;
      first_opsel_q <= '0;
      first_exp_q   <= '0;
      first_act_q   <= '0;
      sig_q         <= '0;
    end else begin
      state_q       <= state_d;
      checked_q     <= checked_d;
      errors_q      <= errors_d;
      skipped_q     <= skipped_d;
      fail_q        <= fail_d;
      first_opsel_q <= first_opsel_d;
      first_exp_q   <= first_exp_d;
      first_act_q   <= first_act_d;
      sig_q         <= sig_d;
    end
  end

  assign o_checked     = checked_q;
  assign o_errors      = errors_q;
  assign o_skipped     = skipped_q;
  assign o_fail        = fail_q;
  assign o_first_opsel = first_opsel_q;
  assign o_first_exp   = first_exp_q;
  assign o_first_act   = first_act_q;
  assign o_signature   = sig_q;

endmodule

// File: tb/tb_main_alu_checker.sv
// Directed bench for main_alu_checker: four instances cover LATENCY 1/2/3
// and a narrow counter width; expected values are hand-computed constants.
module tb_main_alu_checker;

  logic        clk = 1'b0;
  logic        valid  [4];
  logic [31:0] op1    [4];
  logic [31:0] op2    [4];
  logic [3:0]  opsel  [4];
  logic [31:0] aluout [4];
  logic        clr    [4];
  logic        rstn   [4];

  logic [15:0] a_checked, a_errors, a_skipped;
  logic        a_fail;
  logic [3:0]  a_fop;
  logic [31:0] a_fexp, a_fact, a_sig;
  logic [3:0]  s_checked, s_errors, s_skipped;
  logic        s_fail;
  logic [3:0]  s_fop;
  logic [31:0] s_fexp, s_fact, s_sig;
  logic [15:0] t_checked, t_errors, t_skipped;
  logic        t_fail;
  logic [3:0]  t_fop;
  logic [31:0] t_fexp, t_fact, t_sig;
  logic [15:0] d_checked, d_errors, d_skipped;
  logic        d_fail;
  logic [3:0]  d_fop;
  logic [31:0] d_fexp, d_fact, d_sig;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  main_alu_checker #(.LATENCY(1), .CNT_W(16)) u_a (
    .i_clk(clk), .i_rst_n(rstn[0]), .i_valid(valid[0]), .i_op1(op1[0]), .i_op2(op2[0]),
    .i_opsel(opsel[0]), .i_aluout(aluout[0]), .i_clear(clr[0]),
    .o_checked(a_checked), .o_errors(a_errors), .o_skipped(a_skipped), .o_fail(a_fail),
    .o_first_opsel(a_fop), .o_first_exp(a_fexp), .o_first_act(a_fact), .o_signature(a_sig));

  main_alu_checker #(.LATENCY(1), .CNT_W(4)) u_s (
    .i_clk(clk), .i_rst_n(rstn[1]), .i_valid(valid[1]), .i_op1(op1[1]), .i_op2(op2[1]),
    .i_opsel(opsel[1]), .i_aluout(aluout[1]), .i_clear(clr[1]),
    .o_checked(s_checked), .o_errors(s_errors), .o_skipped(s_skipped), .o_fail(s_fail),
    .o_first_opsel(s_fop), .o_first_exp(s_fexp), .o_first_act(s_fact), .o_signature(s_sig));

  main_alu_checker #(.LATENCY(3), .CNT_W(16)) u_t (
    .i_clk(clk), .i_rst_n(rstn[2]), .i_valid(valid[2]), .i_op1(op1[2]), .i_op2(op2[2]),
    .i_opsel(opsel[2]), .i_aluout(aluout[2]), .i_clear(clr[2]),
    .o_checked(t_checked), .o_errors(t_errors), .o_skipped(t_skipped), .o_fail(t_fail),
    .o_first_opsel(t_fop), .o_first_exp(t_fexp), .o_first_act(t_fact), .o_signature(t_sig));

  main_alu_checker #(.LATENCY(2), .CNT_W(16)) u_d (
    .i_clk(clk), .i_rst_n(rstn[3]), .i_valid(valid[3]), .i_op1(op1[3]), .i_op2(op2[3]),
    .i_opsel(opsel[3]), .i_aluout(aluout[3]), .i_clear(clr[3]),
    .o_checked(d_checked), .o_errors(d_errors), .o_skipped(d_skipped), .o_fail(d_fail),
    .o_first_opsel(d_fop), .o_first_exp(d_fexp), .o_first_act(d_fact), .o_signature(d_sig));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] s, input logic [31:0] out);
    valid[k]  = v;
    op1[k]    = a;
    op2[k]    = b;
    opsel[k]  = s;
    aluout[k] = out;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      drive(k, 1'b0, '0, '0, '0, '0);
      clr[k]  = 1'b0;
      rstn[k] = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < 4; k++) rstn[k] = 1'b1;
    tick();

    chk("rst_a_checked", a_checked, 0);  chk("rst_a_errors", a_errors, 0);
    chk("rst_a_skipped", a_skipped, 0);  chk("rst_a_fail", a_fail, 0);
    chk("rst_a_fop", a_fop, 0);          chk("rst_a_fexp", a_fexp, 0);
    chk("rst_a_fact", a_fact, 0);        chk("rst_a_sig", a_sig, 0);
    chk("rst_s_checked", s_checked, 0);  chk("rst_s_errors", s_errors, 0);
    chk("rst_s_skipped", s_skipped, 0);  chk("rst_s_fail", s_fail, 0);
    chk("rst_s_fop", s_fop, 0);          chk("rst_s_fexp", s_fexp, 0);
    chk("rst_s_fact", s_fact, 0);        chk("rst_s_sig", s_sig, 0);
    chk("rst_t_skipped", t_skipped, 0);  chk("rst_t_fail", t_fail, 0);
    chk("rst_t_fop", t_fop, 0);          chk("rst_t_fexp", t_fexp, 0);
    chk("rst_t_fact", t_fact, 0);        chk("rst_t_sig", t_sig, 0);
    chk("rst_d_skipped", d_skipped, 0);  chk("rst_d_fail", d_fail, 0);
    chk("rst_d_fop", d_fop, 0);          chk("rst_d_fexp", d_fexp, 0);
    chk("rst_d_fact", d_fact, 0);

    // ADD 5+7, result presented one cycle later
    drive(0, 1'b1, 32'd5, 32'd7, 4'b0000, 32'h0);
    tick();
    drive(0, 1'b0, 32'd0, 32'd0, 4'b0000, 32'd12);
    tick();
    chk("add_checked", a_checked, 1);
    chk("add_errors", a_errors, 0);
    chk("add_fail", a_fail, 0);
    chk("add_sig", a_sig, 32'h0000000C);

    // SUB 3-5 answered with 0, then XOR 0xF0^0x0F answered wrongly
    drive(0, 1'b1, 32'd3, 32'd5, 4'b1000, 32'h0);
    tick();
    drive(0, 1'b1, 32'hF0, 32'h0F, 4'b0100, 32'h0);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h12345678);
    tick();
    chk("mis_errors", a_errors, 2);
    chk("mis_fail", a_fail, 1);
    chk("mis_first_opsel", a_fop, 4'b1000);
    chk("mis_first_exp", a_fexp, 32'hFFFFFFFE);
    chk("mis_first_act", a_fact, 32'h0);
    chk("mis_checked", a_checked, 3);
    chk("mis_sig", a_sig, 32'h12345648);

    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("clr_checked", a_checked, 0);
    chk("clr_errors", a_errors, 0);
    chk("clr_fail", a_fail, 0);
    chk("clr_first_exp", a_fexp, 0);
    chk("clr_sig", a_sig, 0);

    // SRA, SLT, SLTU correct, then an undefined opsel
    drive(0, 1'b1, 32'h80000000, 32'd4, 4'b1101, 32'h0);
    tick();
    drive(0, 1'b1, 32'hFFFFFFFF, 32'd1, 4'b0010, 32'hF8000000);
    tick();
    drive(0, 1'b1, 32'hFFFFFFFF, 32'd1, 4'b0011, 32'd1);
    tick();
    drive(0, 1'b1, 32'h0, 32'h0, 4'b1111, 32'd0);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 4'b0000, 32'hDEADBEEF);
    tick();
    chk("sra_checked", a_checked, 3);
    chk("sra_errors", a_errors, 0);
    chk("sra_skipped", a_skipped, 1);
    chk("sra_fail", a_fail, 0);
    chk("sra_sig", a_sig, 32'hE0000001);

    // SLL (shift taken from op2[4:0]), SRL, OR, AND, ADD wraparound
    drive(0, 1'b1, 32'h0000000F, 32'h24, 4'b0001, 32'h0);
    tick();
    drive(0, 1'b1, 32'hF0000000, 32'd4, 4'b0101, 32'h000000F0);
    tick();
    drive(0, 1'b1, 32'hF0, 32'h0F, 4'b0110, 32'h0F000000);
    tick();
    drive(0, 1'b1, 32'hFF0, 32'h0FF, 4'b0111, 32'hFF);
    tick();
    drive(0, 1'b1, 32'hFFFFFFFF, 32'd1, 4'b0000, 32'h0F0);
    tick();
    drive(0, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0);
    tick();
    chk("ops_checked", a_checked, 8);
    chk("ops_errors", a_errors, 0);

    // Narrow counters: 20 correct ADDs saturate at 15
    for (int i = 0; i < 20; i++) begin
      drive(1, 1'b1, 32'(i), 32'd1, 4'b0000, 32'(i));
      tick();
    end
    drive(1, 1'b0, 32'h0, 32'h0, 4'b0000, 32'd20);
    tick();
    chk("sat_checked", s_checked, 4'hF);
    chk("sat_errors", s_errors, 0);

    drive(1, 1'b1, 32'd1, 32'd1, 4'b0000, 32'h0);
    tick();
    drive(1, 1'b0, 32'h0, 32'h0, 4'b0000, 32'd99);
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    chk("clrmis_checked", s_checked, 0);
    chk("clrmis_errors", s_errors, 0);
    chk("clrmis_fail", s_fail, 0);
    chk("clrmis_fop", s_fop, 0);
    chk("clrmis_sig", s_sig, 0);

    // LATENCY=3: only the third cycle after issue is compared
    drive(2, 1'b1, 32'd2, 32'd3, 4'b0000, 32'hBAD);
    tick();
    drive(2, 1'b0, 32'h0, 32'h0, 4'b0000, 32'hBAD);
    tick();
    tick();
    aluout[2] = 32'd5;
    tick();
    chk("l3_checked", t_checked, 1);
    chk("l3_errors", t_errors, 0);
    aluout[2] = 32'hBAD;
    tick();
    chk("l3_idle_checked", t_checked, 1);
    chk("l3_idle_errors", t_errors, 0);

    // LATENCY=3: reset discards an in-flight mismatching op
    drive(2, 1'b1, 32'd1, 32'd1, 4'b0000, 32'h0);
    tick();
    drive(2, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0);
    tick();
    rstn[2] = 1'b0;
    #1;
    chk("l3_async_checked", t_checked, 0);
    tick();
    rstn[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("l3_post_rst_errors", t_errors, 0);
      chk("l3_post_rst_checked", t_checked, 0);
    end

    // LATENCY=2: alternating valid, odd slots carry garbage
    for (int c = 0; c < 10; c++) begin
      drive(3, (c < 8) && (c % 2 == 0), 32'(c), 32'(c), 4'b0000,
            ((c >= 2) && (c % 2 == 0)) ? 32'(2 * (c - 2)) : 32'hBAD);
      tick();
      chk("l2_checked", d_checked, (c >= 2) ? 32'(c / 2) : 32'd0);
    end
    chk("l2_errors", d_errors, 0);
    chk("l2_sig", d_sig, 32'h0000000C);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/main_alu_checker.md
Name: main_alu_checker

Overview:
- Self-checking response end for the main_alu stimulus path. It receives each ALU operation issued to the ALU and the ALU output LATENCY cycles later.
- It recomputes the expected result with an internal reference model, compares it against the ALU output, and keeps pass/fail status, counters, first-failure capture and a running output signature.
- It sits beside main_alu in hardware test tops, replacing the keep-only result register with an observable verdict.

Parameters:
- LATENCY, 1, cycles from operand issue to valid i_aluout (legal 1..4)
- CNT_W, 16, width of the check, error and skip counters

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  operation issued to ALU this cycle
- i_op1  in  32  operand 1 as issued
- i_op2  in  32  operand 2 as issued
- i_opsel  in  4  ALU operation select as issued
- i_aluout  in  32  ALU result, aligned LATENCY cycles after issue
- i_clear  in  1  synchronous clear of status, counters, captures and signature
- o_checked  out  CNT_W  number of compared operations
- o_errors  out  CNT_W  number of mismatches
- o_skipped  out  CNT_W  valid operations with undefined opsel
- o_fail  out  1  sticky: at least one mismatch since reset/clear
- o_first_opsel  out  4  opsel of the first mismatch
- o_first_exp  out  32  expected value of the first mismatch
- o_first_act  out  32  actual value of the first mismatch
- o_signature  out  32  rolling signature of compared i_aluout values

Behaviour:
- Reset (async assert, sync release): all outputs 0, delay pipeline valid bits 0, FSM = RUN.
- Opsel encoding for the reference model (shift amount is op2[4:0]; SLT is signed):
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU
  - 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND
  - all other codes are undefined.
- Expected result is computed at issue and carried through a LATENCY-deep register pipeline with its valid, defined-flag and opsel. The stage at depth LATENCY is compared with i_aluout in the same cycle. Status outputs update on the following edge.
- Valid bits are 0 after reset, so no comparison occurs in the first LATENCY cycles.
- Aligned stage valid & defined:
  - o_checked += 1
  - o_signature <= {sig[30:0], sig[31]} ^ i_aluout
  - on mismatch, o_errors += 1
- Aligned stage valid & undefined: o_skipped += 1; no compare, signature unchanged.
- All three counters saturate at all-ones; they never wrap.
- FSM states:
  - RUN: first mismatch captures o_first_* and sets o_fail; go to FAILED.
  - FAILED: further mismatches only count errors; captures are frozen.
  - i_clear returns to RUN.
- i_clear:
  - Zeros counters, o_fail, captures and signature. It has priority over an update in the same cycle, so a mismatch aligned with the clear is discarded.
  - The pipeline is not flushed; in-flight operations are compared in later cycles.
- Reset mid-operation: everything, including in-flight pipeline entries, is discarded immediately.
- i_valid low: that slot produces no compare, and pipeline bubbles are preserved.

Test Plan:
- LATENCY=1, issue ADD 5,7, drive i_aluout=12 next cycle -> o_checked=1, o_errors=0, o_fail=0, o_signature=0x0000000C.
- Issue SUB 3,5 with i_aluout=0, then XOR with a wrong output -> o_errors=2, o_fail=1, o_first_opsel=1000, o_first_exp=0xFFFFFFFE, o_first_act=0 (not overwritten by the second mismatch).
- Correct SRA 0x80000000>>4=0xF8000000, SLT 0xFFFFFFFF,1=1 and SLTU 0xFFFFFFFF,1=0; then opsel 1111 -> o_checked=3, o_errors=0, o_skipped=1.
- CNT_W=4, 20 correct back-to-back ops -> o_checked saturates at 15. Then i_clear in the same cycle as an aligned mismatch -> all status 0 and o_fail=0.
- LATENCY=3: issue mismatching op, then assert i_rst_n=0 for 1 cycle before it aligns -> o_errors stays 0 and no compare occurs for 3 cycles after release.
- Alternate i_valid 1/0 with LATENCY=2 for 8 cycles -> o_checked=4, and compares occur only in the slots matching valid issues.
